// File: rtl/fault_reporter.sv
// fault_reporter: debounces a per-measurement fault level into a confirmed
// fault, counts confirmations and sends a "FIM\n" report over a UART 8N1 line
// for every new confirmation.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | no confirmed fault; run counter counts consecutive faulty ticks
// CONFIRMED | fault confirmed; run counter counts consecutive clean ticks
// TX_IDLE   | line idle high, waiting for a request or a pending report
// START     | start bit (low) for one bit period
// DATA      | 8 data bits, LSB first, one bit period each
// STOP      | stop bit (high) for one bit period
// NEXT      | single cycle: advance to the next byte or finish the report
module fault_reporter #(
    parameter int CLKS_PER_BIT = 434,
    parameter int CONFIRM_CNT  = 3,
    parameter int CLEAR_CNT    = 3
) (
    input  logic       clk_50M,
    input  logic       rst,
    input  logic       fault_in,
    input  logic       meas_tick,
    output logic       tx,
    output logic       fault_led,
    output logic       busy,
    output logic [7:0] fault_count
);

    localparam int RUN_MAX = (CONFIRM_CNT > CLEAR_CNT) ? CONFIRM_CNT : CLEAR_CNT;
    localparam int RUN_W   = (RUN_MAX > 1) ? $clog2(RUN_MAX) : 1;
    localparam int BAUD_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [RUN_W-1:0]  CONFIRM_LAST = RUN_W'(CONFIRM_CNT - 1);
    localparam logic [RUN_W-1:0]  CLEAR_LAST   = RUN_W'(CLEAR_CNT - 1);
    localparam logic [BAUD_W-1:0] BAUD_LOAD    = BAUD_W'(CLKS_PER_BIT - 1);

    typedef enum logic {
        IDLE,
        CONFIRMED
    } det_state_t;

    typedef enum logic [2:0] {
        TX_IDLE,
        START,
        DATA,
        STOP,
        NEXT
    } tx_state_t;

    det_state_t        det_state, det_state_n;
    logic [RUN_W-1:0]  run_cnt, run_cnt_n;
    logic              confirm;

    tx_state_t         tx_state, tx_state_n;
    logic [BAUD_W-1:0] baud_cnt, baud_cnt_n;
    logic [2:0]        bit_idx, bit_idx_n;
    logic [1:0]        byte_idx, byte_idx_n;
    logic              pending, pending_n;
    logic              tx_n;
    logic [7:0]        cur_byte;

    // Detector next state: count consecutive ticks that disagree with the current state.
    always_comb begin
        det_state_n = det_state;
        run_cnt_n   = run_cnt;
        confirm     = 1'b0;
        if (meas_tick) begin
            case (det_state)
                IDLE: begin
                    if (fault_in) begin
                        if (run_cnt == CONFIRM_LAST) begin
                            det_state_n = CONFIRMED;
                            run_cnt_n   = '0;
                            confirm     = 1'b1;
                        end else begin
                            run_cnt_n = run_cnt + RUN_W'(1);
                        end
                    end else begin
                        run_cnt_n = '0;
                    end
                end
                CONFIRMED: begin
                    if (!fault_in) begin
                        if (run_cnt == CLEAR_LAST) begin
                            det_state_n = IDLE;
                            run_cnt_n   = '0;
                        end else begin
                            run_cnt_n = run_cnt + RUN_W'(1);
                        end
                    end else begin
                        run_cnt_n = '0;
                    end
                end
                default: begin
                    det_state_n = IDLE;
                    run_cnt_n   = '0;
                end
            endcase
        end
    end

    // Report text lookup, indexed by the byte currently being sent.
    always_comb begin
        cur_byte = 8'h46;
        case (byte_idx)
            2'd0:    cur_byte = 8'h46;
            2'd1:    cur_byte = 8'h49;
            2'd2:    cur_byte = 8'h4D;
            default: cur_byte = 8'h0A;
        endcase
    end

    // Transmitter next state; the next line level is computed here so tx leaves a flop.
    always_comb begin
        tx_state_n = tx_state;
        baud_cnt_n = baud_cnt;
        bit_idx_n  = bit_idx;
        byte_idx_n = byte_idx;
        pending_n  = pending;
        tx_n       = tx;
        case (tx_state)
            TX_IDLE: begin
                tx_n = 1'b1;
                if (confirm || pending) begin
                    tx_state_n = START;
                    baud_cnt_n = BAUD_LOAD;
                    bit_idx_n  = '0;
                    byte_idx_n = '0;
                    pending_n  = 1'b0;
                    tx_n       = 1'b0;
                end
            end
            START: begin
                if (baud_cnt == '0) begin
                    tx_state_n = DATA;
                    baud_cnt_n = BAUD_LOAD;
                    bit_idx_n  = '0;
                    tx_n       = cur_byte[0];
                end else begin
                    baud_cnt_n = baud_cnt - BAUD_W'(1);
                end
            end
            DATA: begin
                if (baud_cnt == '0) begin
                    baud_cnt_n = BAUD_LOAD;
                    if (bit_idx == 3'd7) begin
                        tx_state_n = STOP;
                        tx_n       = 1'b1;
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                        tx_n      = cur_byte[bit_idx + 3'd1];
                    end
                end else begin
                    baud_cnt_n = baud_cnt - BAUD_W'(1);
                end
            end
            STOP: begin
                tx_n = 1'b1;
                if (baud_cnt == '0) begin
                    tx_state_n = NEXT;
                end else begin
                    baud_cnt_n = baud_cnt - BAUD_W'(1);
                end
            end
            NEXT: begin
                if (byte_idx == 2'd3) begin
                    tx_state_n = TX_IDLE;
                    byte_idx_n = '0;
                    tx_n       = 1'b1;
                end else begin
                    tx_state_n = START;
                    byte_idx_n = byte_idx + 2'd1;
                    baud_cnt_n = BAUD_LOAD;
                    tx_n       = 1'b0;
                end
            end
            default: begin
                tx_state_n = TX_IDLE;
                tx_n       = 1'b1;
            end
        endcase
        // A request that cannot start now is remembered once; extra ones are dropped.
        if (confirm && (tx_state != TX_IDLE) && !pending) begin
            pending_n = 1'b1;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk_50M or posedge rst) begin
        if (rst) begin
            det_state   <= IDLE;
            run_cnt     <= '0;
            fault_led   <= 1'b0;
            fault_count <= '0;
            tx_state    <= TX_IDLE;
            baud_cnt    <= '0;
            bit_idx     <= '0;
            byte_idx    <= '0;
            pending     <= 1'b0;
            tx          <= 1'b1;
            busy        <= 1'b0;
        end else begin
            det_state <= det_state_n;
            run_cnt   <= run_cnt_n;
            fault_led <= (det_state_n == CONFIRMED);
            if (confirm && (fault_count != 8'hFF)) begin
                fault_count <= fault_count + 8'd1;
            end
            tx_state <= tx_state_n;
            baud_cnt <= baud_cnt_n;
            bit_idx  <= bit_idx_n;
            byte_idx <= byte_idx_n;
            pending  <= pending_n;
            tx       <= tx_n;
            busy     <= (tx_state_n != TX_IDLE);
        end
    end

endmodule
